// File: rtl/div_sched.sv
// div_sched: sequencing controller for the shared iterative divider.
// Resolves divide-by-zero and signed overflow locally, reuses the last
// divider result when the operands match, and survives flushes while the
// divider is busy.
module div_sched #(
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic [1:0]            req_op,
  input  logic [WORD_WIDTH-1:0] req_dividend,
  input  logic [WORD_WIDTH-1:0] req_divisor,
  output logic                  req_ready,
  input  logic                  flush,
  output logic                  div_start,
  output logic                  div_signed,
  output logic [WORD_WIDTH-1:0] div_dividend,
  output logic [WORD_WIDTH-1:0] div_divisor,
  input  logic [WORD_WIDTH-1:0] div_quotient,
  input  logic [WORD_WIDTH-1:0] div_remainder,
  input  logic                  div_finish,
  output logic                  rsp_valid,
  output logic [WORD_WIDTH-1:0] rsp_data,
  output logic                  busy
);

  localparam logic [WORD_WIDTH-1:0] W_MIN = {1'b1, {(WORD_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_ABORT} state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_div_signed, r_rem;
  logic [WORD_WIDTH-1:0] r_div_dividend, r_div_divisor, r_rsp_data;
  logic                  r_c_vld, r_c_sgn;
  logic [WORD_WIDTH-1:0] r_c_dvd, r_c_dvs, r_c_q, r_c_r;

  logic                  w_sgn, w_rem, w_dbz, w_ovf, w_hit, w_fast, w_accept;
  logic                  w_rsp_valid, w_fin;
  logic [WORD_WIDTH-1:0] w_fast_data;

  // Request classification: op[0]=0 is signed, op[1]=1 selects remainder.
  assign w_sgn  = ~req_op[0];
  assign w_rem  = req_op[1];
  assign w_dbz  = (req_divisor == '0);
  assign w_ovf  = w_sgn && (req_dividend == W_MIN) && (req_divisor == '1);
  assign w_hit  = r_c_vld && (r_c_dvd == req_dividend) && (r_c_dvs == req_divisor) &&
                  (r_c_sgn == w_sgn);
  assign w_fast = w_dbz || w_ovf || w_hit;

  // Priority: divide-by-zero, then overflow, then cache hit.
  assign w_fast_data = w_dbz ? (w_rem ? req_dividend : '1) :
                       w_ovf ? (w_rem ? '0 : W_MIN) :
                               (w_rem ? r_c_r : r_c_q);

  // Divider completion only counts while we are waiting on it.
  assign w_fin = div_finish && ((r_state == S_WAIT) || (r_state == S_ABORT));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and handshake/control outputs.
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    div_start   = 1'b0;
    w_rsp_valid = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = !flush;
        w_accept  = req_valid && !flush;
        if (w_accept) w_state_nxt = w_fast ? S_RESP : S_ISSUE;
      end
      // The start pulse goes out even under flush: operands are committed.
      S_ISSUE: begin
        div_start   = 1'b1;
        w_state_nxt = flush ? S_ABORT : S_WAIT;
      end
      // A flush coinciding with finish drops the response but keeps the result.
      S_WAIT: begin
        if (div_finish) w_state_nxt = flush ? S_IDLE : S_RESP;
        else if (flush) w_state_nxt = S_ABORT;
      end
      S_RESP: begin
        w_rsp_valid = !flush;
        w_state_nxt = S_IDLE;
      end
      S_ABORT: begin
        if (div_finish) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand latch, result register and result cache.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_signed   <= 1'b0;
      r_rem          <= 1'b0;
      r_div_dividend <= '0;
      r_div_divisor  <= '0;
      r_rsp_data     <= '0;
      r_c_vld        <= 1'b0;
      r_c_sgn        <= 1'b0;
      r_c_dvd        <= '0;
      r_c_dvs        <= '0;
      r_c_q          <= '0;
      r_c_r          <= '0;
    end else begin
      if (w_accept) begin
        if (w_fast) begin
          r_rsp_data <= w_fast_data;
        end else begin
          r_div_signed   <= w_sgn;
          r_rem          <= w_rem;
          r_div_dividend <= req_dividend;
          r_div_divisor  <= req_divisor;
        end
      end
      if (w_fin) begin
        r_c_vld    <= 1'b1;
        r_c_sgn    <= r_div_signed;
        r_c_dvd    <= r_div_dividend;
        r_c_dvs    <= r_div_divisor;
        r_c_q      <= div_quotient;
        r_c_r      <= div_remainder;
        r_rsp_data <= r_rem ? div_remainder : div_quotient;
      end
    end
  end

  assign rsp_valid    = w_rsp_valid;
  assign rsp_data     = w_rsp_valid ? r_rsp_data : '0;
  assign busy         = (r_state != S_IDLE);
  assign div_signed   = r_div_signed;
  assign div_dividend = r_div_dividend;
  assign div_divisor  = r_div_divisor;

endmodule

// File: tb/tb_div_sched.sv
// tb_div_sched: table vectors, hand sequences for flush/reset, and random
// requests against a spec-level model with a stub iterative divider.
module tb_div_sched;
  localparam int W = 32;
  localparam logic [31:0] MIN  = 32'h8000_0000;
  localparam logic [31:0] ONES = 32'hFFFF_FFFF;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid = 1'b0, flush = 1'b0;
  logic [1:0]  req_op = 2'b00;
  logic [31:0] req_dividend = '0, req_divisor = '0;
  logic        req_ready, div_start, div_signed, rsp_valid, busy;
  logic [31:0] div_dividend, div_divisor, rsp_data;
  logic [31:0] div_quotient = '0, div_remainder = '0;
  logic        div_finish = 1'b0;

  div_sched #(.WORD_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op),
    .req_dividend(req_dividend), .req_divisor(req_divisor), .req_ready(req_ready),
    .flush(flush), .div_start(div_start), .div_signed(div_signed),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .div_finish(div_finish), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Stub divider: finish pulse arrives stub_lat cycles after the start cycle.
  int   stub_lat = 4;
  int   stub_cnt = 0;
  logic stub_busy = 1'b0;
  always @(posedge clk) begin
    div_finish <= 1'b0;
    if (div_start) begin
      stub_busy <= 1'b1;
      stub_cnt  <= stub_lat - 1;
      if (div_signed) begin
        div_quotient  <= $signed(div_dividend) / $signed(div_divisor);
        div_remainder <= $signed(div_dividend) % $signed(div_divisor);
      end else begin
        div_quotient  <= div_dividend / div_divisor;
        div_remainder <= div_dividend % div_divisor;
      end
    end else if (stub_busy) begin
      if (stub_cnt == 1) begin
        div_finish <= 1'b1;
        stub_busy  <= 1'b0;
      end else stub_cnt <= stub_cnt - 1;
    end
  end

  // Reference model: RISC-V division semantics plus a one-entry result memory.
  logic        m_vld = 1'b0, m_s = 1'b0;
  logic [31:0] m_a = '0, m_b = '0;

  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int sa, sb;
    int unsigned ua, ub;
    logic rem, sgn;
    rem = op[1]; sgn = !op[0];
    sa = a; sb = b; ua = a; ub = b;
    if (b == 0) return rem ? a : ONES;
    if (sgn && a == MIN && b == ONES) return rem ? 32'd0 : MIN;
    if (sgn) return rem ? 32'(sa % sb) : 32'(sa / sb);
    return rem ? 32'(ua % ub) : 32'(ua / ub);
  endfunction

  // One request through the handshake; checks data, path and timing vs model.
  task automatic do_req(input string nm, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int lat,
                        output logic [31:0] data, output logic fast);
    logic [31:0] exp_d;
    logic        exp_fast, sgn;
    int st_c, fin_c, rsp_c, nstart, bad_busy;
    sgn      = !op[0];
    exp_d    = ref_res(op, a, b);
    exp_fast = (b == 0) || (sgn && a == MIN && b == ONES) ||
               (m_vld && m_a == a && m_b == b && m_s == sgn);
    stub_lat = lat;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_dividend = a; req_divisor = b;
    #1 chk({nm, "_ready"}, {31'd0, req_ready}, 32'd1);
    st_c = -1; fin_c = -1; rsp_c = -1; nstart = 0; bad_busy = 0; data = '0;
    for (int c = 1; c <= 300 && rsp_c < 0; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (div_start) begin nstart++; if (st_c < 0) st_c = c; end
      if (div_finish && fin_c < 0) fin_c = c;
      if (busy !== 1'b1) bad_busy++;
      if (rsp_valid) begin rsp_c = c; data = rsp_data; end
    end
    fast = (nstart == 0);
    chk({nm, "_rsp_seen"}, {31'd0, rsp_c > 0}, 32'd1);
    chk({nm, "_busy"}, bad_busy, 0);
    chk({nm, "_fast"}, {31'd0, fast}, {31'd0, exp_fast});
    chk({nm, "_data"}, data, exp_d);
    if (exp_fast) chk({nm, "_rsp_cyc"}, rsp_c, 1);
    else begin
      chk({nm, "_start_cyc"}, st_c, 1);
      chk({nm, "_nstart"}, nstart, 1);
      chk({nm, "_rsp_cyc"}, rsp_c, fin_c + 1);
      m_vld = 1'b1; m_a = a; m_b = b; m_s = sgn;
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b;
    int          lat;
    logic [31:0] exp;
    logic        fast;
  } vec_t;

  vec_t tbl[14];

  initial begin
    logic [31:0] d, a, b, pa, pb;
    logic        f;
    int          n_rsp, n_rdy, n_busy;
    logic        got_fin;

    // DIV=00 DIVU=01 REM=10 REMU=11
    tbl[0]  = '{2'b01, 32'd100,      32'd7,        33, 32'd14,       1'b0};
    tbl[1]  = '{2'b00, 32'hFFFF_FFF9, 32'd2,        5, 32'hFFFF_FFFD, 1'b0};
    tbl[2]  = '{2'b10, 32'hFFFF_FFF9, 32'd2,        5, 32'hFFFF_FFFF, 1'b1};
    tbl[3]  = '{2'b10, 32'd5,        32'd0,         5, 32'd5,        1'b1};
    tbl[4]  = '{2'b01, 32'd5,        32'd0,         5, 32'hFFFF_FFFF, 1'b1};
    tbl[5]  = '{2'b00, MIN,          ONES,          5, MIN,          1'b1};
    tbl[6]  = '{2'b10, MIN,          ONES,          5, 32'd0,        1'b1};
    tbl[7]  = '{2'b01, MIN,          ONES,          4, 32'd0,        1'b0};
    tbl[8]  = '{2'b11, MIN,          ONES,          4, MIN,          1'b1};
    tbl[9]  = '{2'b00, 32'hFFFF_FFF9, 32'd2,        3, 32'hFFFF_FFFD, 1'b0};
    tbl[10] = '{2'b11, 32'd100,      32'd7,         6, 32'd2,        1'b0};
    tbl[11] = '{2'b01, 32'd100,      32'd7,         6, 32'd14,       1'b1};
    tbl[12] = '{2'b10, 32'd7,        32'hFFFF_FFFE, 2, 32'd1,        1'b0};
    tbl[13] = '{2'b11, 32'd7,        32'hFFFF_FFFE, 2, 32'd7,        1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_div_start", {31'd0, div_start}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_div_dividend", div_dividend, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("rst_ready", {31'd0, req_ready}, 32'd1);

    // Table vectors
    for (int i = 0; i < 14; i++) begin
      do_req($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].lat, d, f);
      chk($sformatf("tbl%0d_vec_data", i), d, tbl[i].exp);
      chk($sformatf("tbl%0d_vec_fast", i), {31'd0, f}, {31'd0, tbl[i].fast});
    end

    // Flush in WAIT during DIV 9/3
    stub_lat = 10;
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b00; req_dividend = 32'd9; req_divisor = 32'd3;
    @(negedge clk); req_valid = 1'b0;
    #1 chk("flw_start", {31'd0, div_start}, 32'd1);
    @(negedge clk);
    @(negedge clk); flush = 1'b1;
    #1 chk("flw_ready_flush", {31'd0, req_ready}, 32'd0);
    n_rsp = 0; n_rdy = 0; got_fin = 1'b0;
    @(negedge clk); flush = 1'b0;
    for (int i = 0; i < 60 && !got_fin; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      if (rsp_valid) n_rsp++;
      if (req_ready) n_rdy++;
      if (div_finish) got_fin = 1'b1;
    end
    chk("flw_finish_seen", {31'd0, got_fin}, 32'd1);
    chk("flw_no_rsp", n_rsp, 0);
    chk("flw_ready_low", n_rdy, 0);
    @(negedge clk);
    #1;
    chk("flw_ready_after", {31'd0, req_ready}, 32'd1);
    chk("flw_rsp_after", {31'd0, rsp_valid}, 32'd0);
    m_vld = 1'b1; m_a = 32'd9; m_b = 32'd3; m_s = 1'b1;
    do_req("flw_rem_hit", 2'b10, 32'd9, 32'd3, 5, d, f);
    chk("flw_rem_hit_fast", {31'd0, f}, 32'd1);

    // Flush in RESP suppresses the response; flush in IDLE blocks accept
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b10; req_dividend = 32'd5; req_divisor = 32'd0;
    @(negedge clk); req_valid = 1'b0; flush = 1'b1;
    #1;
    chk("flr_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("flr_rsp_data", rsp_data, 32'd0);
    @(negedge clk); req_valid = 1'b1; flush = 1'b1;
    #1;
    chk("fli_busy", {31'd0, busy}, 32'd0);
    chk("fli_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk); req_valid = 1'b0; flush = 1'b0;
    #1 chk("fli_no_accept", {31'd0, busy}, 32'd0);

    // Reset while in WAIT
    stub_lat = 8;
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b00; req_dividend = 32'd20; req_divisor = 32'd6;
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 chk("rsw_signed_before", {31'd0, div_signed}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rsw_busy", {31'd0, busy}, 32'd0);
    chk("rsw_div_signed", {31'd0, div_signed}, 32'd0);
    chk("rsw_div_dividend", div_dividend, 32'd0);
    chk("rsw_div_divisor", div_divisor, 32'd0);
    chk("rsw_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    n_rsp = 0; n_busy = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid) n_rsp++;
      if (busy) n_busy++;
    end
    chk("rsw_stale_rsp", n_rsp, 0);
    chk("rsw_stale_busy", n_busy, 0);
    m_vld = 1'b0;
    do_req("rsw_rem", 2'b10, 32'd20, 32'd6, 4, d, f);
    chk("rsw_rem_slow", {31'd0, f}, 32'd0);

    // Random requests against the model
    pa = 32'd9; pb = 32'd3;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0: a = $urandom;
        1: a = MIN;
        2: a = $urandom_range(0, 20);
        default: a = pa;
      endcase
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = ONES;
        2: b = $urandom;
        3: b = $urandom_range(1, 9);
        default: b = pb;
      endcase
      do_req($sformatf("rnd%0d", i), 2'($urandom_range(0, 3)), a, b,
             $urandom_range(2, 6), d, f);
      pa = a; pb = b;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_sched.md
# div_sched

Sequencing controller for the shared iterative divider in the CPU execute stage. Accepts DIV/DIVU/REM/REMU requests over a valid/ready handshake and resolves RISC-V corner cases (divide-by-zero, signed overflow) without the divider. Reuses the last divider result when a REM follows a DIV on the same operands, or vice versa. Issues single-cycle starts to the divider, drives the pipeline stall, and tolerates flushes while the divider is running.

## Interface
- `WORD_WIDTH`, 32, operand/result width
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `req_valid`  in  1  request present
- `req_op`  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- `req_dividend`  in  WORD_WIDTH  dividend
- `req_divisor`  in  WORD_WIDTH  divisor
- `req_ready`  out  1  request accepted when `req_valid && req_ready`
- `flush`  in  1  discard current/pending operation
- `div_start`  out  1  one-cycle start pulse to divider
- `div_signed`  out  1  1 = signed divide; held from ISSUE through WAIT
- `div_dividend`, `div_divisor`  out  WORD_WIDTH  latched operands, held stable until `div_finish`
- `div_quotient`, `div_remainder`  in  WORD_WIDTH  divider results, valid with `div_finish`
- `div_finish`  in  1  one-cycle divider completion
- `rsp_valid`  out  1  one-cycle result pulse, no backpressure
- `rsp_data`  out  WORD_WIDTH  quotient or remainder per op
- `busy`  out  1  stall request to pipeline; `state != IDLE`

## Operation
- States: IDLE, ISSUE, WAIT, RESP, ABORT.
- `req_ready = (state == IDLE) && !flush`.
- On accept in IDLE, classify the request in priority order:
  1. Divide-by-zero (divisor == 0): quotient = all ones; remainder = dividend. Go to RESP.
  2. Signed overflow (signed op, dividend == 0x8000_0000, divisor == 0xFFFF_FFFF): quotient = 0x8000_0000; remainder = 0. Go to RESP.
  3. Cache hit (cache valid, and dividend, divisor and signedness all equal the cached values): select the cached quotient or remainder. Go to RESP.
  4. Otherwise: latch the operands and signedness. Go to ISSUE.
- ISSUE: assert `div_start` for exactly one cycle, then go to WAIT.
- WAIT: on `div_finish`:
  - write `div_quotient`, `div_remainder`, the operands and signedness into the cache; set cache valid;
  - register the selected result (quotient for DIV/DIVU, remainder for REM/REMU);
  - go to RESP.
- RESP: assert `rsp_valid` with `rsp_data` for one cycle, then go to IDLE.
- Fast paths (1 and 2) never touch the divider or the cache.
- Flush handling:
  - ISSUE with `flush`: `div_start` is still pulsed, then go to ABORT. The divider cannot be cancelled once operands are latched.
  - WAIT with `flush`: go to ABORT.
  - ABORT: `req_ready` = 0. On `div_finish`, fill the cache (the result is still correct for those operands), emit no response, go to IDLE.
  - RESP with `flush`: `rsp_valid` is suppressed; go to IDLE.
  - IDLE with `flush`: no accept.
- `div_finish` outside WAIT/ABORT is ignored.
- Reset: state = IDLE; cache valid = 0. All outputs 0 except `req_ready`, which is 1 once `rst_n` is high (IDLE, no flush). Reset during any state abandons the operation immediately; no `rsp_valid`.

## Timing
- Accept at cycle t.
- Fast path or cache hit: `rsp_valid` at t+1.
- Divider path: `div_start` at t+1. If `div_finish` arrives at cycle f, `rsp_valid` is at f+1.
- Back-to-back: the next accept is possible in the cycle after RESP. Minimum two cycles per request.
- `rsp_data` is registered; it is 0 whenever `rsp_valid` = 0.
- `busy` is registered state; it is high from t+1 until the cycle after RESP/ABORT exits.
- Operands on `div_*` change only on the ISSUE entry edge.

## Test plan
- DIVU 100/7 with a stub divider finishing 33 cycles after start:
  - `div_start` at t+1;
  - `rsp_valid` with `rsp_data` = 14, one cycle after `div_finish`;
  - `busy` high throughout.
- DIV then REM, both on -7, 2:
  - first response = 0xFFFF_FFFD;
  - REM produces no `div_start`; `rsp_data` = 0xFFFF_FFFF at t+1.
- Divide-by-zero: REM 5/0 returns 5 at t+1; DIVU 5/0 returns 0xFFFF_FFFF. No `div_start` in either case.
- Signed overflow: DIV 0x8000_0000 / 0xFFFF_FFFF returns 0x8000_0000, and REM on the same operands returns 0, each at t+1 with no `div_start`. DIVU on the same operands takes the divider path (quotient 0).
- Flush in WAIT during DIV 9/3:
  - no `rsp_valid`; `req_ready` stays 0 until after `div_finish`;
  - a following REM 9/3 hits the cache and returns 0 at t+1.
- Assert reset in WAIT: state returns to IDLE, all outputs return to 0 and the cache is invalidated. After release, a REM on the same operands issues `div_start`.
